// File: rtl/pq_arbiter_if.sv
// ---------------------------------------------------------------------------
// pq_arbiter_if
//
// Bundles the requester handshake and the priority-queue command bus that
// pq_arbiter sits between.
//
// Requester side (per requester k, packed into vectors):
//   i_req_valid [NUM_REQ]          request valid
//   i_req_op    [2*NUM_REQ]        op per requester: 01 enq, 10 deq, 11 replace
//   i_req_data  [DATA_WIDTH*NUM_REQ] insert/replace data, slice k
//   o_req_ready [NUM_REQ]          one-hot accept
//   o_rsp_valid [NUM_REQ]          one-hot response pulse (deq/replace)
//   o_rsp_data  [DATA_WIDTH]       popped value, qualified by o_rsp_valid
//   o_err                          pulse on acceptance of an illegal op
// Queue side:
//   o_pq_wrt / o_pq_read           queue command strobes
//   o_pq_data   [DATA_WIDTH]       queue insert data
//   i_pq_full / i_pq_empty         queue status
//   i_pq_data   [DATA_WIDTH]       current queue head
//
// Modports: slave = the arbiter's view, master = the environment's view.
// ---------------------------------------------------------------------------
interface pq_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [2*NUM_REQ-1:0]          i_req_op;
    logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic [NUM_REQ-1:0]            o_rsp_valid;
    logic [DATA_WIDTH-1:0]         o_rsp_data;
    logic                          o_err;

    logic                          o_pq_wrt;
    logic                          o_pq_read;
    logic [DATA_WIDTH-1:0]         o_pq_data;
    logic                          i_pq_full;
    logic                          i_pq_empty;
    logic [DATA_WIDTH-1:0]         i_pq_data;

    modport slave (
        input  i_req_valid, i_req_op, i_req_data,
        input  i_pq_full, i_pq_empty, i_pq_data,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_err,
        output o_pq_wrt, o_pq_read, o_pq_data
    );

    modport master (
        output i_req_valid, i_req_op, i_req_data,
        output i_pq_full, i_pq_empty, i_pq_data,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_err,
        input  o_pq_wrt, o_pq_read, o_pq_data
    );
endinterface

// File: rtl/pq_arbiter.sv
// ---------------------------------------------------------------------------
// pq_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share one priority queue.
// One command is issued at a time; each issued command is followed by a
// response cycle and an ISSUE_GAP-cycle cooldown so the queue's sift-down
// can settle before the next command.
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   DATA_WIDTH queue data width
//   ISSUE_GAP  cooldown cycles after each command (1..15)
//
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous, active-high reset
//   bus  pq_arbiter_if.slave: requester handshake + queue command bus
//
// Operation sequence: IDLE (arbitrate, register grant) -> ISSUE (ready,
// queue strobes, sample head) -> RESP (response pulse for deq/replace)
// -> COOLDOWN (ISSUE_GAP cycles) -> IDLE.
// ---------------------------------------------------------------------------
module pq_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ISSUE_GAP  = 4
) (
    input  logic         CLK,
    input  logic         RST,
    pq_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP,
        S_COOLDOWN
    } state_t;

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_ENQ     = 2'b01,
        OP_DEQ     = 2'b10,
        OP_REPL    = 2'b11
    } op_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       grant_d;
    logic [IDX_W-1:0]       rr_ptr_q;
    op_t                    op_q;
    op_t                    op_cur;
    logic [3:0]             cnt_q;
    logic [DATA_WIDTH-1:0]  pq_data_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;
    logic [DATA_WIDTH-1:0]  req_data_cur;
    logic [NUM_REQ-1:0]     eligible;
    logic                   any_eligible;
    int                     rr_idx;

    // -----------------------------------------------------------------------
    // Eligibility: a request is only worth granting if the queue can take
    // it right now. Replace and illegal ops never block, so an illegal op is
    // accepted (and flagged) rather than left hanging.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            // NOTE: every bit gets a value on every pass through this block;
            // a path that skips an assignment would infer a latch.
            eligible[k] = 1'b0;
            if (bus.i_req_valid[k]) begin
                case (bus.i_req_op[2*k +: 2])
                    2'b01:   eligible[k] = !bus.i_pq_full;
                    2'b10:   eligible[k] = !bus.i_pq_empty;
                    default: eligible[k] = 1'b1;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first eligible requester at or after rr_ptr,
    // wrapping at NUM_REQ. Works for non-power-of-two NUM_REQ.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_d      = rr_ptr_q;
        any_eligible = 1'b0;
        rr_idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!any_eligible && eligible[rr_idx]) begin
                any_eligible = 1'b1;
                grant_d      = IDX_W'(rr_idx);
            end
        end
    end

    // The granted requester's op and data are only looked at during ISSUE;
    // the requester holds them stable until it sees ready.
    assign op_cur       = op_t'(bus.i_req_op[2*grant_q +: 2]);
    assign req_data_cur = bus.i_req_data[DATA_WIDTH*grant_q +: DATA_WIDTH];

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (any_eligible) state_d = S_ISSUE;
            S_ISSUE:    state_d = S_RESP;
            S_RESP:     state_d = S_COOLDOWN;
            S_COOLDOWN: if (cnt_q == 4'd0) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers: grant, round-robin pointer, latched op, cooldown
    // counter and the two held data outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            op_q       <= OP_ILLEGAL;
            cnt_q      <= 4'd0;
            pq_data_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_eligible) grant_q <= grant_d;
                end
                S_ISSUE: begin
                    op_q      <= op_cur;
                    pq_data_q <= req_data_cur;
                    // Only ops that pop update the response register, so
                    // o_rsp_data keeps the last popped value across enqueues.
                    if (op_cur == OP_DEQ || op_cur == OP_REPL) begin
                        rsp_data_q <= bus.i_pq_data;
                    end
                    rr_ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
                S_RESP: begin
                    cnt_q <= 4'(ISSUE_GAP - 1);
                end
                S_COOLDOWN: begin
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    //
    // Pulses are masked while RST is high, so a reset raised in the middle
    // of an operation cannot leak a ready, response or queue strobe in the
    // cycle it is asserted; the registers then clear on the edge.
    // o_pq_data shows the live slice during ISSUE (the queue samples it with
    // the strobe) and the registered copy otherwise.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.o_req_ready = '0;
        bus.o_rsp_valid = '0;
        bus.o_err       = 1'b0;
        bus.o_pq_wrt    = 1'b0;
        bus.o_pq_read   = 1'b0;
        bus.o_pq_data   = pq_data_q;
        bus.o_rsp_data  = rsp_data_q;

        if (state_q == S_ISSUE) begin
            bus.o_pq_data = req_data_cur;
        end

        if (!RST) begin
            case (state_q)
                S_ISSUE: begin
                    bus.o_req_ready = NUM_REQ'(1) << grant_q;
                    case (op_cur)
                        OP_ENQ:  bus.o_pq_wrt  = 1'b1;
                        OP_DEQ:  bus.o_pq_read = 1'b1;
                        OP_REPL: begin
                            bus.o_pq_wrt  = 1'b1;
                            bus.o_pq_read = 1'b1;
                        end
                        default: bus.o_err = 1'b1;
                    endcase
                end
                S_RESP: begin
                    if (op_q == OP_DEQ || op_q == OP_REPL) begin
                        bus.o_rsp_valid = NUM_REQ'(1) << grant_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pq_arbiter
//
// Directed bench for pq_arbiter with NUM_REQ=4, DATA_WIDTH=16, ISSUE_GAP=4.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// Grant-to-grant distance under continuous load is one IDLE arbitration
// cycle + ISSUE + RESP + ISSUE_GAP cooldown cycles.
// ---------------------------------------------------------------------------
module tb_pq_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DATA_WIDTH   = 16;
    localparam int ISSUE_GAP    = 4;
    localparam int GRANT_PERIOD = 3 + ISSUE_GAP;
    localparam int WAIT_BUDGET  = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   waited;
    int   t_last;
    logic seen;

    pq_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    pq_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ISSUE_GAP  (ISSUE_GAP)
    ) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int k, input logic v, input logic [1:0] op,
                           input logic [DATA_WIDTH-1:0] d);
        bus.i_req_valid[k]                        = v;
        bus.i_req_op[2*k +: 2]                    = op;
        bus.i_req_data[DATA_WIDTH*k +: DATA_WIDTH] = d;
    endtask

    task automatic settle();
        bus.i_req_valid = '0;
        repeat (GRANT_PERIOD + 1) tick();
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (bus.o_req_ready == '0 && n < WAIT_BUDGET) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(bus.o_req_ready != '0), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 32'(bus.o_req_ready), 32'd0);
        check({tag, "_rsp"},   32'(bus.o_rsp_valid), 32'd0);
        check({tag, "_err"},   32'(bus.o_err),       32'd0);
        check({tag, "_wrt"},   32'(bus.o_pq_wrt),    32'd0);
        check({tag, "_read"},  32'(bus.o_pq_read),   32'd0);
    endtask

    initial begin
        bus.i_req_valid = '0;
        bus.i_req_op    = '0;
        bus.i_req_data  = '0;
        bus.i_pq_full   = 1'b0;
        bus.i_pq_empty  = 1'b0;
        bus.i_pq_data   = '0;

        // ---- reset state ----
        rst = 1'b1;
        repeat (2) tick();
        check_quiet("rst");
        check("rst_pq_data",  32'(bus.o_pq_data),  32'd0);
        check("rst_rsp_data", 32'(bus.o_rsp_data), 32'd0);
        rst = 1'b0;
        tick();

        // ---- single enqueue from req0 ----
        set_req(0, 1'b1, 2'b01, 16'h0042);
        tick();
        check("enq_ready", 32'(bus.o_req_ready), 32'h1);
        check("enq_wrt",   32'(bus.o_pq_wrt),    32'd1);
        check("enq_read",  32'(bus.o_pq_read),   32'd0);
        check("enq_err",   32'(bus.o_err),       32'd0);
        check("enq_data",  32'(bus.o_pq_data),   32'h0042);
        t_last = cyc;
        tick();
        check_quiet("enq_resp");
        check("enq_hold_data", 32'(bus.o_pq_data), 32'h0042);
        set_req(0, 1'b1, 2'b01, 16'h0043);
        wait_ready("enq2", waited);
        check("enq_gap",   32'(cyc - t_last),    32'(GRANT_PERIOD));
        check("enq2_data", 32'(bus.o_pq_data),   32'h0043);
        settle();

        // ---- round-robin, all requesters enqueueing from reset ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, 2'b01, 16'(16'h0100 + k));
        for (int n = 0; n < 5; n++) begin
            wait_ready($sformatf("rr%0d", n), waited);
            check($sformatf("rr%0d_grant", n), 32'(bus.o_req_ready), 32'(1 << (n % NUM_REQ)));
            check($sformatf("rr%0d_data", n),  32'(bus.o_pq_data),   32'(16'h0100 + (n % NUM_REQ)));
            if (n > 0) check($sformatf("rr%0d_gap", n), 32'(cyc - t_last), 32'(GRANT_PERIOD));
            t_last = cyc;
            tick();
        end
        settle();

        // ---- dequeue on req2 (rr_ptr = 1) ----
        bus.i_pq_data = 16'h0007;
        set_req(2, 1'b1, 2'b10, 16'h0000);
        wait_ready("deq", waited);
        check("deq_ready", 32'(bus.o_req_ready), 32'h4);
        check("deq_read",  32'(bus.o_pq_read),   32'd1);
        check("deq_wrt",   32'(bus.o_pq_wrt),    32'd0);
        bus.i_req_valid = '0;
        tick();
        check("deq_rsp_valid", 32'(bus.o_rsp_valid), 32'h4);
        check("deq_rsp_data",  32'(bus.o_rsp_data),  32'h0007);
        bus.i_pq_data = 16'h0009;
        tick();
        check("deq_rsp_clear", 32'(bus.o_rsp_valid), 32'h0);
        check("deq_rsp_hold",  32'(bus.o_rsp_data),  32'h0007);
        settle();

        // ---- full blocking: req0 enqueue stalls, req1 dequeue goes ----
        bus.i_pq_full = 1'b1;
        set_req(0, 1'b1, 2'b01, 16'h000A);
        set_req(1, 1'b1, 2'b10, 16'h0000);
        wait_ready("full", waited);
        check("full_grant", 32'(bus.o_req_ready), 32'h2);
        check("full_read",  32'(bus.o_pq_read),   32'd1);
        bus.i_req_valid[1] = 1'b0;
        seen = 1'b0;
        repeat (3 * GRANT_PERIOD) begin
            tick();
            if (bus.o_req_ready != '0) seen = 1'b1;
        end
        check("full_stall", 32'(seen), 32'd0);
        bus.i_pq_full = 1'b0;
        wait_ready("unfull", waited);
        check("unfull_grant", 32'(bus.o_req_ready), 32'h1);
        check("unfull_wrt",   32'(bus.o_pq_wrt),    32'd1);
        check("unfull_data",  32'(bus.o_pq_data),   32'h000A);
        settle();

        // ---- empty blocking: lone dequeue never granted ----
        bus.i_pq_empty = 1'b1;
        set_req(2, 1'b1, 2'b10, 16'h0000);
        seen = 1'b0;
        repeat (3 * GRANT_PERIOD) begin
            tick();
            if (bus.o_req_ready != '0 || bus.o_pq_read) seen = 1'b1;
        end
        check("empty_stall", 32'(seen), 32'd0);
        bus.i_req_valid = '0;

        // ---- replace on an empty queue (req1, rr_ptr = 1) ----
        bus.i_pq_data = 16'h0000;
        set_req(1, 1'b1, 2'b11, 16'h0055);
        wait_ready("repl", waited);
        check("repl_grant", 32'(bus.o_req_ready), 32'h2);
        check("repl_wrt",   32'(bus.o_pq_wrt),    32'd1);
        check("repl_read",  32'(bus.o_pq_read),   32'd1);
        check("repl_data",  32'(bus.o_pq_data),   32'h0055);
        bus.i_req_valid = '0;
        tick();
        check("repl_rsp_valid", 32'(bus.o_rsp_valid), 32'h2);
        check("repl_rsp_data",  32'(bus.o_rsp_data),  32'h0000);
        settle();
        bus.i_pq_empty = 1'b0;

        // ---- illegal op on req3 (rr_ptr = 2) ----
        set_req(3, 1'b1, 2'b00, 16'h0BAD);
        wait_ready("ill", waited);
        check("ill_grant", 32'(bus.o_req_ready), 32'h8);
        check("ill_err",   32'(bus.o_err),       32'd1);
        check("ill_wrt",   32'(bus.o_pq_wrt),    32'd0);
        check("ill_read",  32'(bus.o_pq_read),   32'd0);
        bus.i_req_valid = '0;
        tick();
        check_quiet("ill_resp");
        settle();

        // ---- reset raised during RESP of a dequeue on req2 (rr_ptr = 0) ----
        bus.i_pq_data = 16'h00AA;
        set_req(2, 1'b1, 2'b10, 16'h0000);
        wait_ready("rstop", waited);
        check("rstop_grant", 32'(bus.o_req_ready), 32'h4);
        bus.i_req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        check("rstop_no_rsp", 32'(bus.o_rsp_valid), 32'h0);
        tick();
        check_quiet("rstop_after");
        check("rstop_pq_data",  32'(bus.o_pq_data),  32'd0);
        check("rstop_rsp_data", 32'(bus.o_rsp_data), 32'd0);
        rst = 1'b0;
        // Pointer restarts at 0: req1 wins over req3 (req3 would win from 3).
        set_req(1, 1'b1, 2'b01, 16'h0011);
        set_req(3, 1'b1, 2'b01, 16'h0033);
        wait_ready("rstop_next", waited);
        check("rstop_next_grant", 32'(bus.o_req_ready), 32'h2);
        settle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
